rx_multiblock_decoder: RTL and testbench

// - 64b/66b receive decoder + Clause 82 receive state machine, NB_BLOCKS blocks per clock.
// - Classifies each block (R_TYPE) and maps PCS chars to CGMII.
// - Sequences blocks through RX_INIT/C/D/T/E, substituting EBLOCK_R/LBLOCK_R.
// - Sits after block sync/descrambler; drives the CGMII-side receive interface.

---
 rtl/rx_pcs_pkg.sv | 72 +++++++
 rtl/rx_block_classifier.sv | 96 +++++++++
 rtl/rx_multiblock_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_rx_multiblock_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pcs_pkg.sv
// Shared constants for the 64b/66b receive path: CGMII and PCS characters,
// block-type codes, R_TYPE encoding, receive FSM states and the fixed
// EBLOCK_R / LBLOCK_R substitution patterns.
package rx_pcs_pkg;

  localparam int BLK_W = 66;
  localparam int PAY_W = 64;
  localparam int CTL_W = 8;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // CGMII characters
  localparam logic [7:0] CG_IDLE  = 8'h07;
  localparam logic [7:0] CG_ERROR = 8'hFE;
  localparam logic [7:0] CG_START = 8'hFB;
  localparam logic [7:0] CG_TERM  = 8'hFD;
  localparam logic [7:0] CG_SEQ   = 8'h9C;
  localparam logic [7:0] CG_FSIG  = 8'h5C;

  // 7-bit PCS control characters
  localparam logic [6:0] PCS_IDLE  = 7'h00;
  localparam logic [6:0] PCS_ERROR = 7'h1E;

  // Block-type field values
  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_O  = 8'h4B;
  localparam logic [7:0] BT_S  = 8'h78;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'hAA;
  localparam logic [7:0] BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC;
  localparam logic [7:0] BT_T5 = 8'hD2;
  localparam logic [7:0] BT_T6 = 8'hE1;
  localparam logic [7:0] BT_T7 = 8'hFF;

  // Ordered-set O codes
  localparam logic [3:0] O_SEQ = 4'h0;
  localparam logic [3:0] O_SIG = 4'hF;

  // R_TYPE one-hot {D,S,C,T}; all-zero means E
  localparam logic [3:0] RT_D = 4'b1000;
  localparam logic [3:0] RT_S = 4'b0100;
  localparam logic [3:0] RT_C = 4'b0010;
  localparam logic [3:0] RT_T = 4'b0001;
  localparam logic [3:0] RT_E = 4'b0000;

  typedef enum logic [2:0] {
    RX_INIT = 3'd0,
    RX_C    = 3'd1,
    RX_D    = 3'd2,
    RX_T    = 3'd3,
    RX_E    = 3'd4
  } rx_state_t;

  localparam logic [PAY_W-1:0] EBLOCK_DATA = {8{CG_ERROR}};
  localparam logic [CTL_W-1:0] EBLOCK_CTRL = 8'hFF;
  localparam logic [PAY_W-1:0] LBLOCK_DATA = 64'h9C00_0001_0000_0000;
  localparam logic [CTL_W-1:0] LBLOCK_CTRL = 8'h80;

  // Tk block: bytes k..7 are control on CGMII (T0 -> FF, T3 -> 1F, T7 -> 01)
  function automatic logic [CTL_W-1:0] term_ctrl(input logic [2:0] k);
    return 8'hFF >> k;
  endfunction

  // Only /I/ and /E/ reach this mapping; everything else was classified as E
  function automatic logic [7:0] pcs_to_cgmii(input logic [6:0] c);
    return (c == PCS_IDLE) ? CG_IDLE : CG_ERROR;
  endfunction

endpackage

// File: rtl/rx_block_classifier.sv
// Combinational classification of one 66b block into R_TYPE plus its raw
// CGMII translation. Invalid blocks report R_TYPE E with EBLOCK_R contents.
module rx_block_classifier
  import rx_pcs_pkg::*;
(
  input  logic [BLK_W-1:0] coded,
  output logic [3:0]       r_type,
  output logic [PAY_W-1:0] data,
  output logic [CTL_W-1:0] ctrl
);

  logic [1:0]       sh;
  logic [PAY_W-1:0] pl;
  logic [7:0]       btype;
  logic [PAY_W-1:0] pl_shift;
  logic [3:0]       ocode;
  logic             term_hit;
  logic [2:0]       term_pos;
  logic [7:0]       char_ok;
  logic             term_ok;

  assign sh       = coded[BLK_W-1 -: 2];
  assign pl       = coded[PAY_W-1:0];
  assign btype    = pl[63:56];
  assign pl_shift = {pl[55:0], 8'h00};
  assign ocode    = pl[31:28];

  // Terminate position from the block type
  always_comb begin
    term_hit = 1'b1;
    term_pos = 3'd0;
    case (btype)
      BT_T0:   term_pos = 3'd0;
      BT_T1:   term_pos = 3'd1;
      BT_T2:   term_pos = 3'd2;
      BT_T3:   term_pos = 3'd3;
      BT_T4:   term_pos = 3'd4;
      BT_T5:   term_pos = 3'd5;
      BT_T6:   term_pos = 3'd6;
      BT_T7:   term_pos = 3'd7;
      default: term_hit = 1'b0;
    endcase
  end

  // Per byte position: the 7-bit char packed right-aligned for that byte is /I/ or /E/
  always_comb begin
    char_ok = '0;
    for (int b = 0; b < 8; b++) begin
      char_ok[b] = (pl[7*(7-b) +: 7] == PCS_IDLE) || (pl[7*(7-b) +: 7] == PCS_ERROR);
    end
  end

  // Classification and CGMII translation
  always_comb begin
    r_type  = RT_E;
    data    = EBLOCK_DATA;
    ctrl    = EBLOCK_CTRL;
    term_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b > int'(term_pos) && !char_ok[b]) term_ok = 1'b0;
    end
    if (sh == SH_DATA) begin
      r_type = RT_D;
      data   = pl;
      ctrl   = '0;
    end else if (sh == SH_CTRL) begin
      if (btype == BT_S) begin
        r_type = RT_S;
        data   = {CG_START, pl[55:0]};
        ctrl   = 8'h80;
      end else if (btype == BT_C) begin
        if (&char_ok) begin
          r_type = RT_C;
          ctrl   = 8'hFF;
          for (int b = 0; b < 8; b++) data[8*(7-b) +: 8] = pcs_to_cgmii(pl[7*(7-b) +: 7]);
        end
      end else if (btype == BT_O) begin
        // O code sits just below D3; the 28 bits after it must be zero
        if ((ocode == O_SEQ || ocode == O_SIG) && pl[27:0] == 28'h0) begin
          r_type = RT_C;
          data   = {(ocode == O_SEQ) ? CG_SEQ : CG_FSIG, pl[55:32], 32'h0};
          ctrl   = 8'h80;
        end
      end else if (term_hit && term_ok) begin
        r_type = RT_T;
        ctrl   = term_ctrl(term_pos);
        for (int b = 0; b < 8; b++) begin
          if (b < int'(term_pos))       data[8*(7-b) +: 8] = pl_shift[8*(7-b) +: 8];
          else if (b == int'(term_pos)) data[8*(7-b) +: 8] = CG_TERM;
          else                          data[8*(7-b) +: 8] = pcs_to_cgmii(pl[7*(7-b) +: 7]);
        end
      end
    end
  end

endmodule

// File: rtl/rx_multiblock_decoder.sv
// Multi-block 64b/66b receive decoder with the chained receive state machine.
// A word is decoded once the following word arrives so that the last block
// can look ahead at block 0 of the next word.
module rx_multiblock_decoder
  import rx_pcs_pkg::*;
#(
  parameter int NB_BLOCKS       = 2,
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_RX_DATA     = 64,
  parameter int LEN_RX_CTRL     = 8,
  parameter int NB_ERR_CNT      = 16
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_enable,
  input  logic                                 i_valid,
  input  logic                                 i_block_lock,
  input  logic                                 i_hi_ber,
  input  logic                                 i_clear_err,
  input  logic [NB_BLOCKS*LEN_CODED_BLOCK-1:0] i_rx_coded,
  output logic [NB_BLOCKS*LEN_RX_DATA-1:0]     o_rx_data,
  output logic [NB_BLOCKS*LEN_RX_CTRL-1:0]     o_rx_ctrl,
  output logic [NB_BLOCKS*4-1:0]               o_r_type,
  output logic                                 o_valid,
  output logic [NB_ERR_CNT-1:0]                o_err_count
);

  localparam int W_CODED = NB_BLOCKS*LEN_CODED_BLOCK;

  logic                                  accept;
  logic                                  decode;
  logic [W_CODED-1:0]                    hold_coded_p0;
  logic                                  hold_lock_p0;
  logic                                  hold_hiber_p0;
  logic                                  hold_vld_p0;
  logic                                  link_down;
  rx_state_t                             state_q;
  rx_state_t                             blk_state [NB_BLOCKS];
  logic [NB_BLOCKS-1:0][3:0]             cls_type;
  logic [NB_BLOCKS-1:0][3:0]             nxt_type;
  logic [NB_BLOCKS-1:0][LEN_RX_DATA-1:0] cls_data;
  logic [NB_BLOCKS-1:0][LEN_RX_CTRL-1:0] cls_ctrl;
  logic [3:0]                            la_type;
  logic [LEN_RX_DATA-1:0]                la_data_unused;
  logic [LEN_RX_CTRL-1:0]                la_ctrl_unused;
  logic [NB_BLOCKS*LEN_RX_DATA-1:0]      dec_data;
  logic [NB_BLOCKS*LEN_RX_CTRL-1:0]      dec_ctrl;
  logic [NB_BLOCKS*4-1:0]                dec_type;
  logic [NB_ERR_CNT-1:0]                 err_inc;
  logic [NB_BLOCKS*LEN_RX_DATA-1:0]      data_p1;
  logic [NB_BLOCKS*LEN_RX_CTRL-1:0]      ctrl_p1;
  logic [NB_BLOCKS*4-1:0]                type_p1;
  logic                                  vld_p1;
  logic [NB_ERR_CNT-1:0]                 err_p1;

  assign accept    = i_enable & i_valid;
  assign decode    = accept & hold_vld_p0;
  assign link_down = !hold_lock_p0 || hold_hiber_p0;

  function automatic logic [NB_ERR_CNT-1:0] sat_add(input logic [NB_ERR_CNT-1:0] a,
                                                    input logic [NB_ERR_CNT-1:0] b);
    logic [NB_ERR_CNT:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[NB_ERR_CNT] ? '1 : sum[NB_ERR_CNT-1:0];
  endfunction

  function automatic rx_state_t next_state(input rx_state_t cur, input logic [3:0] cls,
                                           input logic [3:0] nxt);
    logic t_ok;
    t_ok = (cls == RT_T) && (nxt == RT_S || nxt == RT_C);
    next_state = RX_E;
    case (cur)
      RX_INIT, RX_C, RX_T: begin
        if (cls == RT_C)      next_state = RX_C;
        else if (cls == RT_S) next_state = RX_D;
      end
      RX_D: begin
        if (cls == RT_D) next_state = RX_D;
        else if (t_ok)   next_state = RX_T;
      end
      RX_E: begin
        if (cls == RT_C)      next_state = RX_C;
        else if (cls == RT_D) next_state = RX_D;
        else if (t_ok)        next_state = RX_T;
      end
      default: next_state = RX_INIT;
    endcase
  endfunction

  // ---- stage p0: hold register ----
  // Hold register data: the last accepted word with its lock/hi_ber status
  always_ff @(posedge i_clock) begin
    if (accept) begin
      hold_coded_p0 <= i_rx_coded;
      hold_lock_p0  <= i_block_lock;
      hold_hiber_p0 <= i_hi_ber;
    end
  end

  // Hold-valid flag: reset discards a held word so no partial output follows
  always_ff @(posedge i_clock) begin
    if (!i_reset)    hold_vld_p0 <= 1'b0;
    else if (accept) hold_vld_p0 <= 1'b1;
  end

  for (genvar j = 0; j < NB_BLOCKS; j++) begin : g_blk
    rx_block_classifier u_cls (
      .coded  (hold_coded_p0[(NB_BLOCKS-1-j)*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]),
      .r_type (cls_type[j]),
      .data   (cls_data[j]),
      .ctrl   (cls_ctrl[j])
    );
    if (j < NB_BLOCKS-1) begin : g_inner
      assign nxt_type[j] = cls_type[j+1];
    end else begin : g_last
      assign nxt_type[j] = la_type;
    end
  end

  rx_block_classifier u_cls_la (
    .coded  (i_rx_coded[W_CODED-1 -: LEN_CODED_BLOCK]),
    .r_type (la_type),
    .data   (la_data_unused),
    .ctrl   (la_ctrl_unused)
  );

  // FSM state register: carries the last block's state into the next word
  always_ff @(posedge i_clock) begin
    if (!i_reset)    state_q <= RX_INIT;
    else if (decode) state_q <= blk_state[NB_BLOCKS-1];
  end

  // FSM next-state chain: each block's destination seeds the following block
  always_comb begin
    rx_state_t st;
    st = state_q;
    for (int j = 0; j < NB_BLOCKS; j++) begin
      if (link_down) st = RX_INIT;
      else           st = next_state(st, cls_type[j], nxt_type[j]);
      blk_state[j] = st;
    end
  end

  // FSM outputs: per-block data/ctrl chosen by destination state, error tally
  always_comb begin
    dec_data = '0;
    dec_ctrl = '0;
    dec_type = '0;
    err_inc  = '0;
    for (int j = 0; j < NB_BLOCKS; j++) begin
      dec_type[(NB_BLOCKS-1-j)*4 +: 4] = cls_type[j];
      if (link_down) begin
        dec_data[(NB_BLOCKS-1-j)*LEN_RX_DATA +: LEN_RX_DATA] = LBLOCK_DATA;
        dec_ctrl[(NB_BLOCKS-1-j)*LEN_RX_CTRL +: LEN_RX_CTRL] = LBLOCK_CTRL;
      end else if (blk_state[j] == RX_E) begin
        dec_data[(NB_BLOCKS-1-j)*LEN_RX_DATA +: LEN_RX_DATA] = EBLOCK_DATA;
        dec_ctrl[(NB_BLOCKS-1-j)*LEN_RX_CTRL +: LEN_RX_CTRL] = EBLOCK_CTRL;
        err_inc = err_inc + NB_ERR_CNT'(1);
      end else begin
        dec_data[(NB_BLOCKS-1-j)*LEN_RX_DATA +: LEN_RX_DATA] = cls_data[j];
        dec_ctrl[(NB_BLOCKS-1-j)*LEN_RX_CTRL +: LEN_RX_CTRL] = cls_ctrl[j];
      end
    end
  end

  // ---- stage p1: output registers ----
  // Decoded word registers: load per decode, reset to the link-down pattern
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      data_p1 <= {NB_BLOCKS{LBLOCK_DATA}};
      ctrl_p1 <= {NB_BLOCKS{LBLOCK_CTRL}};
      type_p1 <= '0;
    end else if (decode) begin
      data_p1 <= dec_data;
      ctrl_p1 <= dec_ctrl;
      type_p1 <= dec_type;
    end
  end

  // Output valid: one pulse per decoded word, frozen while disabled
  always_ff @(posedge i_clock) begin
    if (!i_reset)      vld_p1 <= 1'b0;
    else if (i_enable) vld_p1 <= decode;
  end

  // Saturating error-block counter; clear wins over increment
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      err_p1 <= '0;
    end else if (i_enable) begin
      if (i_clear_err)  err_p1 <= '0;
      else if (decode)  err_p1 <= sat_add(err_p1, err_inc);
    end
  end

  assign o_rx_data   = data_p1;
  assign o_rx_ctrl   = ctrl_p1;
  assign o_r_type    = type_p1;
  assign o_valid     = vld_p1;
  assign o_err_count = err_p1;

endmodule

// File: tb/tb_rx_multiblock_decoder.sv
// Directed bench for rx_multiblock_decoder with NB_BLOCKS=2.
module tb_rx_multiblock_decoder;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         valid;
  logic         block_lock;
  logic         hi_ber;
  logic         clear_err;
  logic [131:0] rx_coded;
  logic [127:0] rx_data;
  logic [15:0]  rx_ctrl;
  logic [7:0]   r_type;
  logic         out_valid;
  logic [15:0]  err_count;

  int tests = 0;
  int fails = 0;

  // Input blocks
  localparam logic [65:0] B_IDLE = {2'b10, 8'h1E, 56'h0};
  localparam logic [65:0] B_S    = {2'b10, 8'h78, 56'h11_2233_4455_6677};
  localparam logic [65:0] B_D1   = {2'b01, 64'hA0A1_A2A3_A4A5_A6A7};
  localparam logic [65:0] B_D2   = {2'b01, 64'hB0B1_B2B3_B4B5_B6B7};
  localparam logic [65:0] B_T4   = {2'b10, 8'hCC, 32'hC0C1_C2C3, 24'h0};
  localparam logic [65:0] B_T7   = {2'b10, 8'hFF, 56'hD0_D1D2_D3D4_D5D6};
  localparam logic [65:0] B_ERR  = {2'b00, 64'h0};

  // Expected CGMII data per block
  localparam logic [63:0] DAT_I  = 64'h0707_0707_0707_0707;
  localparam logic [63:0] DAT_E  = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [63:0] DAT_L  = 64'h9C00_0001_0000_0000;
  localparam logic [63:0] DAT_S  = 64'hFB11_2233_4455_6677;
  localparam logic [63:0] DAT_D1 = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] DAT_D2 = 64'hB0B1_B2B3_B4B5_B6B7;
  localparam logic [63:0] DAT_T4 = 64'hC0C1_C2C3_FD07_0707;
  localparam logic [63:0] DAT_T7 = 64'hD0D1_D2D3_D4D5_D6FD;

  rx_multiblock_decoder dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_valid      (valid),
    .i_block_lock (block_lock),
    .i_hi_ber     (hi_ber),
    .i_clear_err  (clear_err),
    .i_rx_coded   (rx_coded),
    .o_rx_data    (rx_data),
    .o_rx_ctrl    (rx_ctrl),
    .o_r_type     (r_type),
    .o_valid      (out_valid),
    .o_err_count  (err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [131:0] w, input logic lock, input logic hiber, input logic clr);
    rx_coded   = w;
    valid      = 1'b1;
    block_lock = lock;
    hi_ber     = hiber;
    clear_err  = clr;
    @(posedge clock);
    @(negedge clock);
    valid      = 1'b0;
    block_lock = 1'b1;
    hi_ber     = 1'b0;
    clear_err  = 1'b0;
  endtask

  task automatic send_word(input logic [131:0] w);
    send(w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; valid = 1'b0; block_lock = 1'b1;
    hi_ber = 1'b0; clear_err = 1'b0; rx_coded = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({out_valid, r_type, err_count} !== 25'h0) begin
      fails++; $display("FAIL reset_status: got %h want 0", {out_valid, r_type, err_count});
    end
    tests++;
    if (rx_data !== {DAT_L, DAT_L}) begin
      fails++; $display("FAIL reset_data: got %h want %h", rx_data, {DAT_L, DAT_L});
    end
    tests++;
    if (rx_ctrl !== 16'h8080) begin
      fails++; $display("FAIL reset_ctrl: got %h want 8080", rx_ctrl);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle;
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL idle_first_word_valid: got %b want 0", out_valid);
    end
    send_word({B_IDLE, B_IDLE});
    tests++;
    if ({out_valid, r_type, err_count} !== {1'b1, 8'h22, 16'd0}) begin
      fails++; $display("FAIL idle_status: got %h want %h", {out_valid, r_type, err_count}, {1'b1, 8'h22, 16'd0});
    end
    tests++;
    if (rx_data !== {DAT_I, DAT_I} || rx_ctrl !== 16'hFFFF) begin
      fails++; $display("FAIL idle_data: got %h/%h want %h/FFFF", rx_data, rx_ctrl, {DAT_I, DAT_I});
    end
  endtask

  task automatic test_frame;
    send_word({B_IDLE, B_S});
    send_word({B_D1, B_D2});
    tests++;
    if (rx_data !== {DAT_I, DAT_S} || rx_ctrl !== 16'hFF80 || r_type !== 8'h24) begin
      fails++; $display("FAIL frame_start: got %h/%h/%h want %h/FF80/24", rx_data, rx_ctrl, r_type, {DAT_I, DAT_S});
    end
    send_word({B_T4, B_IDLE});
    tests++;
    if (rx_data !== {DAT_D1, DAT_D2} || rx_ctrl !== 16'h0000 || r_type !== 8'h88) begin
      fails++; $display("FAIL frame_data: got %h/%h/%h want %h/0000/88", rx_data, rx_ctrl, r_type, {DAT_D1, DAT_D2});
    end
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (rx_data !== {DAT_T4, DAT_I} || rx_ctrl !== 16'h0FFF || r_type !== 8'h12 || err_count !== 16'd0) begin
      fails++; $display("FAIL frame_term: got %h/%h/%h/%0d want %h/0FFF/12/0", rx_data, rx_ctrl, r_type, err_count, {DAT_T4, DAT_I});
    end
  endtask

  task automatic test_d_after_idle;
    send_word({B_D1, B_IDLE});
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (rx_data !== {DAT_E, DAT_I} || rx_ctrl !== 16'hFFFF || r_type !== 8'h82 || err_count !== 16'd1) begin
      fails++; $display("FAIL d_after_idle: got %h/%h/%h/%0d want %h/FFFF/82/1", rx_data, rx_ctrl, r_type, err_count, {DAT_E, DAT_I});
    end
  endtask

  task automatic test_t7;
    send_word({B_S, B_D1});
    send_word({B_T7, B_D2});
    tests++;
    if (rx_data !== {DAT_S, DAT_D1} || rx_ctrl !== 16'h8000 || r_type !== 8'h48) begin
      fails++; $display("FAIL t7_frame_open: got %h/%h/%h want %h/8000/48", rx_data, rx_ctrl, r_type, {DAT_S, DAT_D1});
    end
    send_word({B_D1, B_T7});
    tests++;
    if (rx_data !== {DAT_E, DAT_D2} || rx_ctrl !== 16'hFF00 || r_type !== 8'h18 || err_count !== 16'd2) begin
      fails++; $display("FAIL t7_next_d: got %h/%h/%h/%0d want %h/FF00/18/2", rx_data, rx_ctrl, r_type, err_count, {DAT_E, DAT_D2});
    end
    send_word({B_S, B_D2});
    tests++;
    if (rx_data !== {DAT_D1, DAT_T7} || rx_ctrl !== 16'h0001 || r_type !== 8'h81 || err_count !== 16'd2) begin
      fails++; $display("FAIL t7_boundary: got %h/%h/%h/%0d want %h/0001/81/2", rx_data, rx_ctrl, r_type, err_count, {DAT_D1, DAT_T7});
    end
  endtask

  task automatic test_lock_loss;
    send({B_D1, B_D2}, 1'b0, 1'b0, 1'b0);
    tests++;
    if (rx_data !== {DAT_S, DAT_D2} || rx_ctrl !== 16'h8000) begin
      fails++; $display("FAIL lock_prev_word: got %h/%h want %h/8000", rx_data, rx_ctrl, {DAT_S, DAT_D2});
    end
    send_word({B_D1, B_IDLE});
    tests++;
    if (rx_data !== {DAT_L, DAT_L} || rx_ctrl !== 16'h8080 || r_type !== 8'h88 || err_count !== 16'd2) begin
      fails++; $display("FAIL lock_lost: got %h/%h/%h/%0d want %h/8080/88/2", rx_data, rx_ctrl, r_type, err_count, {DAT_L, DAT_L});
    end
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (rx_data !== {DAT_E, DAT_I} || rx_ctrl !== 16'hFFFF || err_count !== 16'd3) begin
      fails++; $display("FAIL lock_regained_d: got %h/%h/%0d want %h/FFFF/3", rx_data, rx_ctrl, err_count, {DAT_E, DAT_I});
    end
    send({B_IDLE, B_IDLE}, 1'b1, 1'b1, 1'b0);
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (rx_data !== {DAT_L, DAT_L} || rx_ctrl !== 16'h8080 || r_type !== 8'h22 || err_count !== 16'd3) begin
      fails++; $display("FAIL hi_ber: got %h/%h/%h/%0d want %h/8080/22/3", rx_data, rx_ctrl, r_type, err_count, {DAT_L, DAT_L});
    end
  endtask

  task automatic test_err_sat;
    send_word({B_ERR, B_ERR});
    repeat (32765) send_word({B_ERR, B_ERR});
    tests++;
    if (err_count !== 16'd65533 || rx_data !== {DAT_E, DAT_E} || r_type !== 8'h00) begin
      fails++; $display("FAIL err_ramp: got %0d/%h/%h want 65533/%h/00", err_count, rx_data, r_type, {DAT_E, DAT_E});
    end
    send_word({B_ERR, B_ERR});
    tests++;
    if (err_count !== 16'hFFFF) begin
      fails++; $display("FAIL err_reach_max: got %h want FFFF", err_count);
    end
    send_word({B_ERR, B_ERR});
    tests++;
    if (err_count !== 16'hFFFF) begin
      fails++; $display("FAIL err_saturate: got %h want FFFF", err_count);
    end
    send({B_ERR, B_ERR}, 1'b1, 1'b0, 1'b1);
    tests++;
    if (err_count !== 16'd0) begin
      fails++; $display("FAIL err_clear: got %0d want 0", err_count);
    end
    send_word({B_ERR, B_ERR});
    tests++;
    if (err_count !== 16'd2) begin
      fails++; $display("FAIL err_after_clear: got %0d want 2", err_count);
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      tests++;
      if (out_valid !== 1'b0 || rx_data !== {DAT_E, DAT_E} || err_count !== 16'd2) begin
        fails++; $display("FAIL gap_hold_%0d: got %b/%h/%0d want 0/%h/2", i, out_valid, rx_data, err_count, {DAT_E, DAT_E});
      end
    end
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (out_valid !== 1'b1 || err_count !== 16'd4) begin
      fails++; $display("FAIL gap_resume: got %b/%0d want 1/4", out_valid, err_count);
    end
    enable = 1'b0; valid = 1'b1; rx_coded = {B_S, B_D1};
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if (out_valid !== 1'b1 || err_count !== 16'd4 || rx_data !== {DAT_E, DAT_E}) begin
      fails++; $display("FAIL freeze: got %b/%0d/%h want 1/4/%h", out_valid, err_count, rx_data, {DAT_E, DAT_E});
    end
    valid = 1'b0; enable = 1'b1;
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (rx_data !== {DAT_I, DAT_I} || r_type !== 8'h22 || err_count !== 16'd4) begin
      fails++; $display("FAIL after_freeze: got %h/%h/%0d want %h/22/4", rx_data, r_type, err_count, {DAT_I, DAT_I});
    end
  endtask

  task automatic test_reset_mid;
    reset = 1'b0; valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    tests++;
    if ({out_valid, r_type, err_count} !== 25'h0 || rx_data !== {DAT_L, DAT_L} || rx_ctrl !== 16'h8080) begin
      fails++; $display("FAIL mid_reset: got %h/%h/%h want 0/%h/8080", {out_valid, r_type, err_count}, rx_data, rx_ctrl, {DAT_L, DAT_L});
    end
    reset = 1'b1;
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (out_valid !== 1'b0 || rx_data !== {DAT_L, DAT_L}) begin
      fails++; $display("FAIL mid_reset_refill: got %b/%h want 0/%h", out_valid, rx_data, {DAT_L, DAT_L});
    end
    send_word({B_IDLE, B_IDLE});
    tests++;
    if (out_valid !== 1'b1 || rx_data !== {DAT_I, DAT_I} || err_count !== 16'd0) begin
      fails++; $display("FAIL mid_reset_resume: got %b/%h/%0d want 1/%h/0", out_valid, rx_data, err_count, {DAT_I, DAT_I});
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_d_after_idle();
    test_t7();
    test_lock_loss();
    test_err_sat();
    test_gaps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
